// File: rtl/multi_chg_tx.sv
// -----------------------------------------------------------------------------
// multi_chg_tx
//
// Watches NCH channels of WIDTH bits each. When a channel's value changes, the
// new value is latched into that channel's snapshot and the channel is flagged
// pending. Pending channels are serviced round-robin. Each serviced channel is
// sent as one ASCII line on an 8N1 UART: WIDTH/4 lowercase hex digits, most
// significant nibble first, then CR LF.
//
// Build option:
//   MULTI_CHG_TX_TAG_EN  when defined, each line starts with the channel index
//                        as one hex digit followed by ':'.
//
// Parameters:
//   NCH              number of channels (1..16)
//   WIDTH            bits per channel (multiple of 4, 4..64)
//   CLOCKS_PER_BAUD  clocks per UART bit (>= 2)
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset    asynchronous active-high reset
//   i_data     channel values, channel k at [k*WIDTH +: WIDTH]
//   o_uart_tx  serial output, idle high
//   o_busy     high while a line is being sent
//   o_pending  per-channel change-awaiting-send flags
//
// State table:
//   IDLE      | line idle high, waits for a pending channel
//   LOAD_BYTE | first clock of a start bit, loads the next character
//   SHIFT     | rest of start bit, 8 data bits LSB first, stop bit
// -----------------------------------------------------------------------------
module multi_chg_tx #(
  parameter int NCH             = 4,
  parameter int WIDTH           = 32,
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NCH*WIDTH-1:0] i_data,
  output logic                 o_uart_tx,
  output logic                 o_busy,
  output logic [NCH-1:0]       o_pending
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ND = WIDTH / 4;
`ifdef MULTI_CHG_TX_TAG_EN
  localparam int TAG_LEN = 2;
`else
  localparam int TAG_LEN = 0;
`endif
  localparam int NBYTES = TAG_LEN + ND + 2;
  localparam int IW     = $clog2(NBYTES + 1);
  localparam int BW     = $clog2(CLOCKS_PER_BAUD + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_BYTE,
    SHIFT
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  snap_q [NCH];
  logic [CW-1:0]     rr_q;
  logic [WIDTH-1:0]  buf_q;
  logic [IW-1:0]     byte_idx_q;
  logic [BW-1:0]     baud_q;
  logic [3:0]        bit_q;
  logic [8:0]        shreg_q;
`ifdef MULTI_CHG_TX_TAG_EN
  logic [3:0]        ch_q;
`endif

  logic              sel_found;
  logic [CW-1:0]     sel_ch;
  logic              start;
  logic [7:0]        tx_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h57 + {4'h0, n};
  endfunction

  // Round-robin search: first pending channel at or after rr_q, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!sel_found && o_pending[idx]) begin
        sel_found = 1'b1;
        sel_ch    = CW'(idx);
      end
    end
  end

  assign start = (state_q == IDLE) && sel_found;

  // Character for the current byte position of the line being sent.
  always_comb begin
    tx_char = 8'h0A;
    if (int'(byte_idx_q) == TAG_LEN + ND) tx_char = 8'h0D;
    for (int j = 0; j < ND; j++) begin
      if (int'(byte_idx_q) == TAG_LEN + j) tx_char = hex_char(buf_q[(ND-1-j)*4 +: 4]);
    end
`ifdef MULTI_CHG_TX_TAG_EN
    if (byte_idx_q == IW'(0)) tx_char = hex_char(ch_q);
    if (byte_idx_q == IW'(1)) tx_char = 8'h3A;
`endif
  end

  // Snapshots and pending flags. A change on the selection edge wins over the
  // clear, so the newer value still gets its own line later.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NCH; k++) snap_q[k] <= '0;
      o_pending <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (i_data[k*WIDTH +: WIDTH] != snap_q[k]) begin
          snap_q[k]    <= i_data[k*WIDTH +: WIDTH];
          o_pending[k] <= 1'b1;
        end else if (start && (sel_ch == CW'(k))) begin
          o_pending[k] <= 1'b0;
        end
      end
    end
  end

  // Transmit FSM. The start bit begins on the selection edge; LOAD_BYTE is its
  // first clock, so the SHIFT counter only covers the remaining CLOCKS_PER_BAUD-1.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      o_uart_tx  <= 1'b1;
      o_busy     <= 1'b0;
      rr_q       <= '0;
      buf_q      <= '0;
      byte_idx_q <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '1;
`ifdef MULTI_CHG_TX_TAG_EN
      ch_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          o_uart_tx <= 1'b1;
          if (sel_found) begin
            buf_q      <= snap_q[sel_ch];
`ifdef MULTI_CHG_TX_TAG_EN
            ch_q       <= 4'(sel_ch);
`endif
            rr_q       <= (sel_ch == CW'(NCH-1)) ? '0 : sel_ch + 1'b1;
            byte_idx_q <= '0;
            o_busy     <= 1'b1;
            o_uart_tx  <= 1'b0;
            state_q    <= LOAD_BYTE;
          end
        end
        LOAD_BYTE: begin
          shreg_q <= {1'b1, tx_char};
          baud_q  <= BW'(CLOCKS_PER_BAUD - 2);
          bit_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (baud_q != '0) begin
            baud_q <= baud_q - 1'b1;
          end else if (bit_q == 4'd9) begin
            if (int'(byte_idx_q) == NBYTES - 1) begin
              o_uart_tx <= 1'b1;
              o_busy    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
              o_uart_tx  <= 1'b0;
              state_q    <= LOAD_BYTE;
            end
          end else begin
            // shreg_q holds {stop, data}; after 8 shifts bit 0 is the stop bit.
            o_uart_tx <= shreg_q[0];
            shreg_q   <= {1'b1, shreg_q[8:1]};
            bit_q     <= bit_q + 1'b1;
            baud_q    <= BW'(CLOCKS_PER_BAUD - 1);
          end
        end
        default: begin
          o_uart_tx <= 1'b1;
          o_busy    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/multi_chg_tx.md
MULTI_CHG_TX -- requirements
Module: multi_chg_tx

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of monitored channels (legal 1..16).
REQ-002 SHALL have parameter WIDTH, default 32, meaning bits per channel (multiple of 4, legal 4..64).
REQ-003 SHALL have parameter CLOCKS_PER_BAUD, default 868, meaning clocks per UART bit (legal >= 2).
REQ-004 SHALL have port i_clk  input  1  meaning the single system clock; all logic rising-edge.
REQ-005 SHALL have port i_reset  input  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have port i_data  input  NCH*WIDTH  meaning channel values, synchronous to i_clk; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port o_uart_tx  output  1  meaning serial line, 8N1, idle high.
REQ-008 SHALL have port o_busy  output  1  meaning a message is in transmission.
REQ-009 SHALL have port o_pending  output  NCH  meaning per-channel change-awaiting-send flags.

Function
REQ-010 SHALL keep a WIDTH-bit snapshot per channel; when i_data channel k differs from its snapshot, it SHALL copy the new value into the snapshot and set o_pending[k] on the same edge.
REQ-011 SHALL, in IDLE with any o_pending bit set, on the next edge select a channel round-robin, copy that channel's snapshot into a send buffer, clear its pending bit, set o_busy, and drive the start bit.
REQ-012 SHALL start the round-robin search at channel (last serviced + 1) mod NCH; after reset the search SHALL start at channel 0.
REQ-013 SHALL leave o_pending[k] set when channel k changes on the same edge the channel is selected; the new value SHALL be sent in a later message.
REQ-014 SHALL coalesce multiple changes on a pending channel into one message carrying the value captured at message start.
REQ-015 SHALL transmit each byte as start bit 0, 8 data bits LSB first, and one stop bit 1, each exactly CLOCKS_PER_BAUD clocks, with no idle gap between bytes of one message.
REQ-016 SHALL format a message as optional tag (REQ-024), then WIDTH/4 hex digits MSB nibble first, then 0x0D, then 0x0A.
REQ-017 SHALL encode each hex digit as ASCII '0'-'9' or lowercase 'a'-'f'.
REQ-018 SHALL run the FSM states IDLE -> LOAD_BYTE -> SHIFT (start, 8 data, stop) -> LOAD_BYTE until the last byte, then IDLE.
REQ-019 SHALL clear o_busy and drive o_uart_tx high on the edge that ends the final stop bit; the next message MAY start one edge later.
REQ-020 SHALL hold o_uart_tx high whenever it is not transmitting a start bit, data bit or stop bit.

Reset
REQ-021 SHALL, while i_reset is high, immediately force o_uart_tx=1, o_busy=0, o_pending=0, all snapshots=0, round-robin pointer=0, and FSM state IDLE, aborting any message in progress.
REQ-022 SHALL, on the first edge after reset release, compare i_data against the zero snapshots, so nonzero channels become pending.

Configuration
REQ-023 SHALL use the macro MULTI_CHG_TX_TAG_EN to select the message tag.
REQ-024 SHALL, with MULTI_CHG_TX_TAG_EN defined, prefix each message with the channel index as one hex digit followed by ':' (0x3A); without it, a message SHALL contain only the hex digits and CR LF.

Verification (NCH=4, WIDTH=32, CLOCKS_PER_BAUD=4, tag enabled unless noted)
REQ-025 SHALL check: after reset, set channel 2 to 0x000000a5 -> line carries "2:000000a5\r\n", 12 bytes in 480 clocks, o_busy high throughout.
REQ-026 SHALL check: channels 0 and 3 change on the same edge -> "0:..." message then "3:..." message, o_pending=4'b1001 then 4'b1000 then 0.
REQ-027 SHALL check: during a channel-0 message, channel 1 changes to 0x11 then 0x22 -> exactly one "1:00000022\r\n" message follows.
REQ-028 SHALL check: channel 0 changes on its selection edge -> two messages for channel 0, the first with the old value and the second with the new value.
REQ-029 SHALL check: assert i_reset mid-byte -> o_uart_tx=1 and o_busy=0 without waiting for an edge, o_pending=0, and no further bytes while inputs are held.
REQ-030 SHALL check: with MULTI_CHG_TX_TAG_EN undefined, channel 2 set to 0x000000a5 -> "000000a5\r\n", 10 bytes in 400 clocks.
